regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of registers, power of two, minimum 4; AW = log2(DEPTH).
REQ-003 SHALL provide parameter NUM_RD, default 2, number of read ports, range 1..4.
REQ-004 SHALL provide parameter SP_INDEX, default 29, index of the stack-pointer register.
REQ-005 SHALL provide parameter SP_RESET, default 65532, reset and clear value of register SP_INDEX.
REQ-006 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports rd_en  input  1 (read enable); rd_addr  input  NUM_RD*AW (packed read addresses, port k at bits [k*AW +: AW]).
REQ-009 SHALL have ports rd_data  output  NUM_RD*DATA_W (read data); rd_busy  output  NUM_RD (per-port pending-write flag).
REQ-010 SHALL have ports wr0_en  input  1, wr0_addr  input  AW, wr0_data  input  DATA_W: ALU write port.
REQ-011 SHALL have ports wr1_en  input  1, wr1_addr  input  AW, wr1_data  input  DATA_W: load-return write port.
REQ-012 SHALL have ports rsv_en  input  1, rsv_addr  input  AW: reserve a register for a pending load.
REQ-013 SHALL have ports clr_req  input  1 (start a flash clear); ready  output  1 (high when not clearing).

Function
REQ-014 Register 0 SHALL read as zero, ignore all writes and never be marked busy.
REQ-015 Writes SHALL commit on the rising edge while wr*_en is high; when wr0 and wr1 target the same address in one cycle, wr0 data SHALL be stored.
REQ-016 Reads SHALL be combinational (zero latency); rd_data for every port SHALL be 0 while rd_en is low.
REQ-017 The scoreboard SHALL keep one busy bit per register: rsv_en sets busy[rsv_addr] and wr1_en clears busy[wr1_addr], both at the next edge; wr0 SHALL NOT affect busy.
REQ-018 When rsv and wr1 hit the same address in one cycle, busy SHALL remain set (the new reservation wins).
REQ-019 rd_busy[k] SHALL equal busy[rd_addr[k]], forced to 0 when rd_en is low or the address is 0.
REQ-020 The FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_req; ready=1 only in IDLE.
REQ-021 CLEAR SHALL walk a counter idx from 1 to DEPTH-1, one register per cycle, writing 0 (SP_RESET at SP_INDEX) and clearing busy[idx]; after idx=DEPTH-1 it SHALL return to IDLE, giving exactly DEPTH-1 cycles with ready low.
REQ-022 In CLEAR, wr0, wr1, rsv and clr_req SHALL be ignored; reads SHALL return current stored contents.

Reset
REQ-023 rst low SHALL asynchronously set all registers to 0 (SP_INDEX to SP_RESET), all busy bits to 0, the FSM to IDLE, idx to 1 and ready to 1, including mid-CLEAR.
REQ-024 rd_data and rd_busy SHALL be 0 during reset whenever rd_en is low.

Configuration
REQ-025 With macro REGFILE_BYPASS_EN defined, a read whose address matches an enabled write port in the same cycle SHALL return the write data (wr0 over wr1) and rd_busy SHALL read 0 when wr1 writes that address; bypass SHALL be suppressed during CLEAR.
REQ-026 Without REGFILE_BYPASS_EN, reads SHALL return the stored pre-edge value and rd_busy the stored busy bit.

Structure
REQ-027 Package regfile_pkg SHALL hold the FSM state enum (RF_IDLE, RF_CLEAR) and default constants DATA_W_DEF, DEPTH_DEF, SP_INDEX_DEF, SP_RESET_DEF.
REQ-028 The busy-bit array with its set/clear/priority logic SHALL be the sub-module regfile_scoreboard.

Verification
REQ-029 After reset, reading addresses 29 and 5 -> 65532 and 0; rd_en=0 -> both ports 0.
REQ-030 wr0 and wr1 both to r7 (0xAAAA, 0x5555) -> next cycle r7=0xAAAA; writing 0x1234 to r0 -> r0 still reads 0.
REQ-031 rsv r9 -> rd_busy=1 next cycle; rsv r9 plus wr1 r9 in the same cycle -> busy stays 1; a later wr1 r9=0x42 -> busy 0, r9=0x42.
REQ-032 With bypass, wr0 r3=0xBEEF while reading r3 -> 0xBEEF the same cycle; without bypass -> old value that cycle, 0xBEEF the next.
REQ-033 clr_req with r4=7 and busy[4]=1 -> ready low for 31 cycles, writes ignored; afterwards r4=0, busy 0, r29=65532.
REQ-034 rst asserted at clear cycle 10 -> immediate IDLE, ready=1, all registers at reset values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default constants for the scoreboarded register file.
// Latency: none; the package holds declarations only.
// Backpressure: none; the package holds declarations only.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int SP_INDEX_DEF = 29;
    localparam int SP_RESET_DEF = 65532;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array that tracks registers awaiting a load return.
// Latency: set and clear take effect at the next rising edge; the busy vector is a direct register output.
// Backpressure: none; every request is applied, and a set beats a clear to the same entry.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    input  logic             flash_en,
    input  logic [AW-1:0]    flash_addr,
    output logic [DEPTH-1:0] busy
);

    logic [DEPTH-1:0] busy_nxt;

    // Next busy state. The clears go first so that a new reservation to the same entry wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (flash_en)
            busy_nxt[flash_addr] = 1'b0;
        if (set_en)
            busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a load scoreboard and a flash clear. Optional write bypass: REGFILE_BYPASS_EN.
// Latency: reads are combinational; writes, reservations and clear steps commit at the next rising edge.
// Backpressure: ready is low for DEPTH-1 cycles during a clear; writes, reserves and clear requests are then dropped without a stall.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int SP_INDEX = SP_INDEX_DEF,
    parameter  int SP_RESET = SP_RESET_DEF,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam logic [AW-1:0]     LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0]     SP_ADDR  = AW'(SP_INDEX);
    localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_RESET);

    rf_state_t         state;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              idle;

    assign idle = (state == RF_IDLE);

    // Clear sequencer: walks idx over 1..DEPTH-1 and then returns to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RF_IDLE;
            idx   <= AW'(1);
            ready <= 1'b1;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state <= RF_CLEAR;
                        ready <= 1'b0;
                    end
                    idx <= AW'(1);
                end
                RF_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state <= RF_IDLE;
                        ready <= 1'b1;
                        idx   <= AW'(1);
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state <= RF_IDLE;
                    ready <= 1'b1;
                    idx   <= AW'(1);
                end
            endcase
        end
    end

    // Register array. A clear step owns the array in CLEAR. In IDLE, wr0 is applied last so it wins an address clash.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (i == SP_INDEX) ? SP_VAL : '0;
        end else if (!idle) begin
            regs[idx] <= (idx == SP_ADDR) ? SP_VAL : '0;
        end else begin
            if (wr1_en && wr1_addr != '0)
                regs[wr1_addr] <= wr1_data;
            if (wr0_en && wr0_addr != '0)
                regs[wr0_addr] <= wr0_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (rsv_en && idle),
        .set_addr   (rsv_addr),
        .clr_en     (wr1_en && idle),
        .clr_addr   (wr1_addr),
        .flash_en   (!idle),
        .flash_addr (idx),
        .busy       (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[k*AW +: AW];

        // Read mux for one port. Output is gated to zero when reads are disabled or the address is r0.
        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (idle && wr0_en && wr0_addr == addr)
                data = wr0_data;
            else if (idle && wr1_en && wr1_addr == addr)
                data = wr1_data;
            if (idle && wr1_en && wr1_addr == addr)
                bsy = 1'b0;
`endif
            if (!rd_en || addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = bsy;
    end

endmodule
